intellight_db_arbiter: RTL and testbench

INTELLIGHT_DB_ARBITER -- requirements
Module: intellight_db_arbiter

---
 rtl/intellight_db_arbiter.sv | 79 +++++++
 tb/tb_intellight_db_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intellight_db_arbiter.sv
// intellight_db_arbiter: two-port arbiter (round-robin with lock) in front of a shared single-port Q-table RAM.
module intellight_db_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  req0,
  input  logic                  we0,
  input  logic                  lock0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t                r_state, w_state_nx;
  logic                  r_win, r_we, r_last, r_last_lock;
  logic [DATA_WIDTH-1:0] r_rdata0, r_rdata1;
  logic                  w_grant, w_win;
  always_comb begin
    w_grant    = (r_state == IDLE) && (req0 || req1);
    w_win      = (req0 && req1) ? (r_last_lock ? r_last : !r_last) : req1;
    w_state_nx = (r_state == IDLE) ? (w_grant ? ISSUE : IDLE) : (r_state == ISSUE) ? DONE : IDLE;
  end
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state     <= IDLE;
      r_win       <= 1'b0;
      r_we        <= 1'b0;
      r_last      <= 1'b1;
      r_last_lock <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      r_state   <= w_state_nx;
      mem_en    <= w_grant;
      mem_we    <= w_grant && (w_win ? we1 : we0);
      mem_addr  <= w_grant ? (w_win ? addr1 : addr0) : '0;
      mem_wdata <= w_grant ? (w_win ? wdata1 : wdata0) : '0;
      ack0      <= (r_state == ISSUE) && !r_win;
      ack1      <= (r_state == ISSUE) && r_win;
      if (w_grant) begin
        r_win <= w_win;
        r_we  <= w_win ? we1 : we0;
      end
      // lock is judged at the ack so a read-modify-write keeps the next tie
      if (r_state == DONE) begin
        r_last      <= r_win;
        r_last_lock <= r_win ? lock1 : lock0;
        if (!r_we && !r_win) r_rdata0 <= mem_rdata;
        if (!r_we && r_win) r_rdata1 <= mem_rdata;
      end
    end
  end
  // read data arrives from the RAM during the ack cycle, then is held
  assign rdata0 = (ack0 && !r_we) ? mem_rdata : r_rdata0;
  assign rdata1 = (ack1 && !r_we) ? mem_rdata : r_rdata1;
  assign busy   = (r_state != IDLE);
endmodule

// File: tb/tb_intellight_db_arbiter.sv
// tb_intellight_db_arbiter: directed scenarios plus random traffic checked against a timeline model of the arbiter.
module tb_intellight_db_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  logic [1:0] req, we, lock;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];
  logic ack0, ack1, mem_en, mem_we, busy;
  logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [DW-1:0] ram [256];
  logic [DW-1:0] mmem [256];
  int ack_q [$];

  intellight_db_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req0(req[0]), .we0(we[0]), .lock0(lock[0]), .addr0(addr[0]), .wdata0(wdata[0]), .ack0(ack0), .rdata0(rdata0),
    .req1(req[1]), .we1(we[1]), .lock1(lock[1]), .addr1(addr[1]), .wdata1(wdata[1]), .ack1(ack1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic ack_of(input int p);
    return p != 0 ? ack1 : ack0;
  endfunction

  function automatic logic [DW-1:0] rdata_of(input int p);
    return p != 0 ? rdata1 : rdata0;
  endfunction

  // synchronous RAM: data appears the cycle after mem_en
  always @(posedge ACLK)
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end

  // model: a grant at edge G puts the access on the RAM for the cycle after G, acks the cycle after that,
  // and the arbiter takes a new request no earlier than edge G+3
  bit m_act = 0;
  bit m_last = 1;
  bit m_lockm = 0;
  bit g_win, g_we;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  int me = 0;
  int g_edge = 0;
  logic [DW-1:0] x_rd [2] = '{32'h0, 32'h0};

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      m_act = 0;
      m_last = 1;
      m_lockm = 0;
      x_rd[0] = '0;
      x_rd[1] = '0;
    end else begin
      me++;
      if (!m_act && req != 2'b00) begin
        if (m_lockm && req[m_last]) g_win = m_last;
        else if (req == 2'b11) g_win = !m_last;
        else g_win = req[1];
        g_we = we[g_win];
        g_addr = addr[g_win];
        g_wdata = wdata[g_win];
        g_edge = me;
        m_act = 1;
      end else if (m_act && me == g_edge + 1) begin
        if (g_we) mmem[g_addr] = g_wdata;
        else x_rd[g_win] = mmem[g_addr];
      end else if (m_act && me == g_edge + 2) begin
        m_last = g_win;
        m_lockm = lock[g_win];
        m_act = 0;
      end
    end
  end

  always @(negedge ACLK) begin
    logic en;
    int k;
    k = me - g_edge;
    en = m_act && k == 0;
    chk("mem_en", mem_en, en);
    chk("mem_we", mem_we, en && g_we);
    chk("mem_addr", mem_addr, en ? g_addr : '0);
    chk("mem_wdata", mem_wdata, en ? g_wdata : '0);
    chk("ack0", ack0, m_act && k == 1 && !g_win);
    chk("ack1", ack1, m_act && k == 1 && g_win);
    chk("busy", busy, m_act);
    chk("rdata0", rdata0, x_rd[0]);
    chk("rdata1", rdata1, x_rd[1]);
    if (ack0) ack_q.push_back(0);
    if (ack1) ack_q.push_back(1);
  end

  task automatic acc(input int p, input logic w, input logic lk, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     output int lat, output logic [DW-1:0] rd, output int ens, output int ac);
    int t0;
    req[p] = 1'b1;
    we[p] = w;
    lock[p] = lk;
    addr[p] = a;
    wdata[p] = d;
    t0 = cyc;
    ens = 0;
    lat = -1;
    rd = '0;
    ac = -1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge ACLK);
      if (mem_en) ens++;
      if (ack_of(p)) begin
        lat = cyc - t0;
        ac = cyc;
        rd = rdata_of(p);
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: port %0d got no ack within 40 cycles", p);
    end
    @(posedge ACLK);
    #1 req[p] = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge ACLK);
    #2 ARESETN = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    #2 ARESETN = 1'b1;
    @(posedge ACLK);
    #1;
  endtask

  task automatic rand_fields(input int p);
    we[p] = 1'($urandom_range(0, 1));
    lock[p] = ($urandom_range(0, 3) == 0);
    addr[p] = AW'($urandom_range(0, 15));
    wdata[p] = $urandom;
  endtask

  initial begin
    int lat, ens, ac0a, ac0b, ac1, l0, l1, e0, e1, d0, d1;
    logic [DW-1:0] rd, r0, r1;
    logic found;
    for (int i = 0; i < 256; i++) begin
      ram[i] = '0;
      mmem[i] = '0;
    end
    mem_rdata = '0;
    req = '0;
    we = '0;
    lock = '0;
    addr[0] = '0;
    addr[1] = '0;
    wdata[0] = '0;
    wdata[1] = '0;
    repeat (3) @(posedge ACLK);
    #2;
    chk("reset_mem_en", mem_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ack1", ack1, 0);
    chk("reset_rdata1", rdata1, 0);
    @(negedge ACLK);
    #2 ARESETN = 1'b1;
    @(posedge ACLK);
    #1;
    // single write then read on port 1
    acc(1, 1'b1, 1'b0, 8'h00, 32'h1, lat, rd, ens, ac1);
    chk("write_latency", lat, 2);
    chk("write_en_cycles", ens, 1);
    acc(1, 1'b0, 1'b0, 8'h00, 32'h0, lat, rd, ens, ac1);
    chk("read_latency", lat, 2);
    chk("read_en_cycles", ens, 1);
    chk("read_data", rd, 32'h1);
    // ties after reset: port 0 first, then the repeated tie goes to port 1
    reset_pulse();
    fork
      begin
        acc(0, 1'b0, 1'b0, 8'h03, 32'h0, l0, r0, e0, ac0a);
        acc(0, 1'b0, 1'b0, 8'h03, 32'h0, d0, r0, e0, ac0b);
      end
      acc(1, 1'b1, 1'b0, 8'h05, 32'h55, l1, r1, e1, ac1);
    join
    chk("tie_p0_latency", l0, 2);
    chk("tie_p1_after_p0", ac1 - ac0a, 3);
    chk("tie_repeat_p0_after_p1", ac0b - ac1, 3);
    // locked read-modify-write by port 0 while port 1 waits
    fork
      begin
        acc(0, 1'b0, 1'b1, 8'h10, 32'h0, l0, r0, e0, ac0a);
        acc(0, 1'b1, 1'b0, 8'h10, 32'h2A, d0, r0, e0, ac0b);
      end
      begin
        @(posedge ACLK);
        #1;
        acc(1, 1'b0, 1'b0, 8'h10, 32'h0, l1, r1, e1, ac1);
      end
    join
    chk("lock_second_p0", ac0b - ac0a, 3);
    chk("lock_p1_last", ac1 - ac0b, 3);
    chk("lock_p1_rdata", r1, 32'h2A);
    // continuous contention alternates
    ack_q.delete();
    fork
      repeat (6) acc(0, 1'b0, 1'b0, AW'($urandom_range(0, 31)), 32'h0, l0, r0, e0, d0);
      repeat (6) acc(1, 1'b1, 1'b0, AW'($urandom_range(32, 63)), $urandom, l1, r1, e1, d1);
    join
    chk("alt_count", ack_q.size(), 12);
    for (int i = 1; i < ack_q.size(); i++) chk("alt_order", ack_q[i] != ack_q[i-1], 1);
    // reset during ISSUE of a port 1 read
    acc(1, 1'b1, 1'b0, 8'h07, 32'h77, lat, rd, ens, ac1);
    req[1] = 1'b1;
    we[1] = 1'b0;
    addr[1] = 8'h07;
    lock[1] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge ACLK);
      found = mem_en;
    end
    chk("rst_issue_seen", found, 1);
    #2 ARESETN = 1'b0;
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_ack1", ack1, 0);
    @(posedge ACLK);
    #1 chk("rst_no_ack", ack1, 0);
    @(negedge ACLK);
    #2 ARESETN = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge ACLK);
      found = ack1;
    end
    chk("rerequest_ack", found, 1);
    chk("rerequest_rdata", rdata1, 32'h77);
    @(posedge ACLK);
    #1 req[1] = 1'b0;
    // address change after grant does not disturb the access
    req[0] = 1'b1;
    we[0] = 1'b0;
    lock[0] = 1'b0;
    addr[0] = 8'h01;
    @(posedge ACLK);
    #1 addr[0] = 8'hFF;
    @(negedge ACLK);
    chk("addr_hold_en", mem_en, 1);
    chk("addr_hold", mem_addr, 8'h01);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge ACLK);
      found = ack0;
    end
    chk("addr_hold_ack", found, 1);
    @(posedge ACLK);
    #1 req[0] = 1'b0;
    // random traffic
    repeat (3000) begin
      @(posedge ACLK);
      #1;
      for (int p = 0; p < 2; p++) begin
        if (!req[p]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[p] = 1'b1;
            rand_fields(p);
          end else if ($urandom_range(0, 3) == 0) lock[p] = 1'($urandom_range(0, 1));
        end else if (ack_of(p)) begin
          req[p] = 1'($urandom_range(0, 1));
          rand_fields(p);
        end else if ($urandom_range(0, 3) == 0) rand_fields(p);
      end
      if ($urandom_range(0, 399) == 0) begin
        ARESETN = 1'b0;
        @(negedge ACLK);
        #2 ARESETN = 1'b1;
      end
    end
    req = '0;
    repeat (5) @(posedge ACLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
